// File: rtl/prn_checker_if.sv
// Stream-in / status-out bundle for the PRN checker.
// Optional bit_cnt member appears when PRN_CHK_BITCNT_EN is defined.
interface prn_checker_if #(
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_bit;
    logic             clr_cnt;
    logic             locked;
    logic             err_pulse;
    logic [CNT_W-1:0] err_cnt;
`ifdef PRN_CHK_BITCNT_EN
    logic [31:0]      bit_cnt;

    modport master (output in_valid, in_bit, clr_cnt,
                    input  locked, err_pulse, err_cnt, bit_cnt);
    modport slave  (input  in_valid, in_bit, clr_cnt,
                    output locked, err_pulse, err_cnt, bit_cnt);
`else
    modport master (output in_valid, in_bit, clr_cnt,
                    input  locked, err_pulse, err_cnt);
    modport slave  (input  in_valid, in_bit, clr_cnt,
                    output locked, err_pulse, err_cnt);
`endif
endinterface

// File: rtl/prn_checker.sv
// Self-synchronising checker for the b[n] = b[n-10] ^ b[n-9] PRN stream.
// Define PRN_CHK_BITCNT_EN to add the 32-bit locked-bit counter (bit_cnt).
module prn_checker #(
    parameter int LOCK_CNT   = 16,
    parameter int WIN_LEN    = 64,
    parameter int UNLOCK_THR = 8,
    parameter int CNT_W      = 16
) (
    input logic          clk,
    input logic          rst,
    prn_checker_if.slave bus
);
    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int WW = $clog2(WIN_LEN + 1);
    localparam int EW = $clog2(UNLOCK_THR + 1);
    localparam logic [MW-1:0] LOCK_M = MW'(LOCK_CNT);
    localparam logic [WW-1:0] WIN_M  = WW'(WIN_LEN);
    localparam logic [EW-1:0] THR_M  = EW'(UNLOCK_THR);

    typedef enum logic {SEARCH, LOCKED} state_e;

    state_e           state_q;
    logic [9:0]       hist_q;
    logic [3:0]       fill_q;
    logic [MW-1:0]    match_q;
    logic [WW-1:0]    win_cnt_q;
    logic [EW-1:0]    win_err_q;
    logic             locked_q;
    logic             err_pulse_q;
    logic [CNT_W-1:0] err_cnt_q;

    logic             pred, bit_err, match_hit;
    logic [MW-1:0]    match_d;
    logic [WW-1:0]    win_cnt_d;
    logic [EW-1:0]    win_err_d;
    logic [CNT_W-1:0] err_cnt_d;

    assign pred      = hist_q[9] ^ hist_q[8];
    assign bit_err   = bus.in_bit != pred;
    // All-zero history predicts zeros forever, so it must never build lock.
    assign match_hit = (fill_q == 4'd10) && (hist_q != '0) && !bit_err;
    assign match_d   = match_q + MW'(1);
    assign win_cnt_d = win_cnt_q + WW'(1);
    assign win_err_d = win_err_q + EW'(bit_err);
    assign err_cnt_d = (&err_cnt_q) ? err_cnt_q : err_cnt_q + CNT_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= SEARCH;
            hist_q      <= '0;
            fill_q      <= '0;
            match_q     <= '0;
            win_cnt_q   <= '0;
            win_err_q   <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            err_pulse_q <= 1'b0;
            if (bus.in_valid) begin
                case (state_q)
                    SEARCH: begin
                        hist_q <= {hist_q[8:0], bus.in_bit};
                        if (fill_q != 4'd10) fill_q <= fill_q + 4'd1;
                        if (!match_hit) begin
                            match_q <= '0;
                        end else if (match_d == LOCK_M) begin
                            state_q   <= LOCKED;
                            locked_q  <= 1'b1;
                            match_q   <= '0;
                            win_cnt_q <= '0;
                            win_err_q <= '0;
                        end else begin
                            match_q <= match_d;
                        end
                    end
                    LOCKED: begin
                        // Free-run on our own prediction so channel errors stay isolated.
                        hist_q      <= {hist_q[8:0], pred};
                        err_pulse_q <= bit_err;
                        if (bit_err) err_cnt_q <= err_cnt_d;
                        if (win_err_d == THR_M) begin
                            state_q   <= SEARCH;
                            locked_q  <= 1'b0;
                            match_q   <= '0;
                            fill_q    <= '0;
                            hist_q    <= '0;
                            win_cnt_q <= '0;
                            win_err_q <= '0;
                        end else if (win_cnt_d == WIN_M) begin
                            win_cnt_q <= '0;
                            win_err_q <= '0;
                        end else begin
                            win_cnt_q <= win_cnt_d;
                            win_err_q <= win_err_d;
                        end
                    end
                    default: state_q <= SEARCH;
                endcase
            end
            if (bus.clr_cnt) err_cnt_q <= '0;
        end
    end

    assign bus.locked    = locked_q;
    assign bus.err_pulse = err_pulse_q;
    assign bus.err_cnt   = err_cnt_q;

`ifdef PRN_CHK_BITCNT_EN
    logic [31:0] bit_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt_q <= '0;
        end else if (bus.clr_cnt) begin
            bit_cnt_q <= '0;
        end else if (bus.in_valid && state_q == LOCKED && !(&bit_cnt_q)) begin
            bit_cnt_q <= bit_cnt_q + 32'd1;
        end
    end

    assign bus.bit_cnt = bit_cnt_q;
`else
    // Bit-error ratio accounting is not built; err_cnt is the only counter.
`endif
endmodule

// File: tb/tb_prn_checker.sv
// Directed scoreboard bench for prn_checker: lock, errors, windowing, gaps, clear, reset.
module tb_prn_checker;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    prn_checker_if #(.CNT_W(16)) bus();
    prn_checker #(.LOCK_CNT(16), .WIN_LEN(64), .UNLOCK_THR(8), .CNT_W(16))
        dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic        locked;
        logic        pulse;
        logic [15:0] cnt;
    } exp_t;

    exp_t        sb[$];
    int          compared   = 0;
    int          mismatched = 0;
    logic [9:0]  gen;
    logic [15:0] ecnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference generator: bit 9 out, D9^D8 fed into D0.
    task automatic next_bit(output logic b);
        b   = gen[9];
        gen = {gen[8:0], gen[9] ^ gen[8]};
    endtask

    task automatic tick(input string tag, input logic v, input logic b, input logic c,
                        input logic el, input logic ep);
        exp_t e;
        e.locked = el;
        e.pulse  = ep;
        e.cnt    = ecnt;
        sb.push_back(e);
        bus.in_valid = v;
        bus.in_bit   = b;
        bus.clr_cnt  = c;
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, "/locked"},    32'(bus.locked),    32'(e.locked));
        chk({tag, "/err_pulse"}, 32'(bus.err_pulse), 32'(e.pulse));
        chk({tag, "/err_cnt"},   32'(bus.err_cnt),   32'(e.cnt));
    endtask

    task automatic good(input string tag, input logic el);
        logic b;
        next_bit(b);
        tick(tag, 1'b1, b, 1'b0, el, 1'b0);
    endtask

    task automatic bad(input string tag, input logic el, input logic clr);
        logic b;
        next_bit(b);
        if (clr) ecnt = '0;
        else if (ecnt != 16'hFFFF) ecnt = ecnt + 16'd1;
        tick(tag, 1'b1, ~b, clr, el, 1'b1);
    endtask

    task automatic idle(input string tag, input logic el);
        logic rb;
        rb = 1'($urandom);
        tick(tag, 1'b0, rb, 1'b0, el, 1'b0);
    endtask

    initial begin
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_bit   = 1'b0;
        bus.clr_cnt  = 1'b0;
        gen          = 10'd1;
        ecnt         = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset/locked",    32'(bus.locked),    32'd0);
        chk("reset/err_pulse", 32'(bus.err_pulse), 32'd0);
        chk("reset/err_cnt",   32'(bus.err_cnt),   32'd0);
        rst = 1'b1;

        // Clean lock after 10 fill bits + 16 matches, then 1000 clean bits.
        for (int n = 1; n <= 1026; n++) good("clean_lock", n >= 26);

        // Single isolated error.
        bad("single_err", 1'b1, 1'b0);
        for (int n = 0; n < 100; n++) good("post_err", 1'b1);

        // Eight errors inside one window drop lock on the eighth.
        for (int i = 0; i < 8; i++) bad("unlock", i < 7, 1'b0);
        for (int n = 1; n <= 26; n++) good("relock", n >= 26);

        // 4+4 errors straddling a window boundary must not unlock.
        for (int n = 0; n < 60; n++) good("win_fill", 1'b1);
        for (int i = 0; i < 8; i++) bad("win_straddle", 1'b1, 1'b0);
        // 4 more on window positions 61..64: the last-bit error unlocks.
        for (int n = 0; n < 56; n++) good("win_fill2", 1'b1);
        for (int i = 0; i < 4; i++) bad("win_last", i < 3, 1'b0);

        // All-zero stream never locks.
        for (int n = 0; n < 200; n++) tick("zeros", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        rst = 1'b0;
        @(posedge clk);
        #1;
        rst  = 1'b1;
        gen  = 10'd1;
        ecnt = '0;

        // Gapped stream: lock point counted in valid bits only.
        for (int n = 1; n <= 30; n++) begin
            good("gap_lock", n >= 26);
            idle("gap_idle", n >= 26);
        end
        bad("gap_err", 1'b1, 1'b0);
        idle("gap_err_idle", 1'b1);
        bad("clr_with_err", 1'b1, 1'b1);
        ecnt = 16'd0;
        tick("clr_idle", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            bad("err_to5", 1'b1, 1'b0);
            good("err_to5_gap", 1'b1);
        end

        // Async reset mid-cycle while locked with err_cnt=5.
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst/locked",    32'(bus.locked),    32'd0);
        chk("async_rst/err_pulse", 32'(bus.err_pulse), 32'd0);
        chk("async_rst/err_cnt",   32'(bus.err_cnt),   32'd0);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/prn_checker.md
Name: prn_checker

Overview:
- Receive-side companion of the team's 10-bit LFSR pseudo-random generator: consumes the serial PRN bit stream, self-synchronises to it, and reports lock and bit errors.
- Sits at the receive end of the loop-back/test path, feeding lock and error status to display and debug logic.
- Stream definition: b[n] = b[n-10] XOR b[n-9]. This matches the generator's register bit 9 output and its feedback of D9 XOR D8 into D0.

Parameters:
- LOCK_CNT, 16: consecutive correct predictions in SEARCH required to assert lock.
- WIN_LEN, 64: length, in valid bits, of the error-monitoring window in LOCKED.
- UNLOCK_THR, 8: errors within one window that force a return to SEARCH.
- CNT_W, 16: width of the error counter.

Ports:
- clk, in, 1: single system clock; all logic on the rising edge.
- rst, in, 1: reset, asynchronous and active-low (0 = reset).
- in_valid, in, 1: in_bit is valid this cycle; idle cycles are allowed anywhere in the stream.
- in_bit, in, 1: received PRN bit.
- clr_cnt, in, 1: synchronous clear of err_cnt (and of bit_cnt when compiled in).
- locked, out, 1: checker is in LOCKED state.
- err_pulse, out, 1: one-cycle pulse, registered, for each mismatched bit while LOCKED.
- err_cnt, out, CNT_W: saturating count of errors seen while LOCKED.

Behaviour:
- Reset values (rst=0, asynchronous): hist=10'd0, state=SEARCH, match_cnt=0, fill_cnt=0, win_cnt=0, win_err=0, locked=0, err_pulse=0, err_cnt=0.
- Internals:
  - hist[9:0]: hist[0] is the newest bit, hist[9] the oldest.
  - pred = hist[9] XOR hist[8], the expected next bit.
- Cycles with in_valid=0: no state change; err_pulse=0.
- SEARCH, on each valid bit:
  - hist shifts in in_bit.
  - fill_cnt counts up and saturates at 10.
  - A bit counts as a match only when fill_cnt==10, hist!=0 (the all-zero history is degenerate and never counts), and in_bit==pred.
  - Match: match_cnt+1. Otherwise: match_cnt=0.
  - When the match would bring match_cnt to LOCK_CNT: go to LOCKED. locked goes to 1 the cycle after that valid bit. win_cnt and win_err are cleared.
- LOCKED, on each valid bit:
  - hist shifts in pred, not in_bit. The local generator free-runs, so a channel error never propagates into later predictions.
  - Mismatch (in_bit != pred): err_pulse=1 the next cycle; err_cnt+1, saturating at all-ones; win_err+1.
  - win_cnt counts valid bits.
  - If win_err reaches UNLOCK_THR within the window: go to SEARCH the next cycle. locked=0, match_cnt=0, fill_cnt=0, hist=0.
  - When win_cnt reaches WIN_LEN without reaching UNLOCK_THR: win_cnt=0, win_err=0.
  - An error landing on the last bit of the window counts in that window first; unlock takes priority over the window reset.
- err_cnt holds its value across SEARCH and is not cleared by loss of lock.
- clr_cnt=1: err_cnt=0 next cycle. If an error occurs in the same cycle, clr_cnt wins and err_cnt=0.
- Reset mid-operation: everything returns to reset values immediately; no partial lock is kept.
- Latency: err_pulse is exactly one clk after the offending valid bit. No combinational path from inputs to outputs.

Optional Feature:
- Macro PRN_CHK_BITCNT_EN.
- When defined:
  - Adds output bit_cnt (32 bits): count of valid bits checked while LOCKED, saturating, cleared by reset and by clr_cnt.
  - Together with err_cnt, this gives a bit-error ratio.
- When undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Clean lock: stream from the generator seeded 10'd1, bit 9, in_valid=1 continuously → locked=1 exactly 1 cycle after valid bit 10+16=26; err_cnt stays 0 for 1000 bits.
- Single error: after lock, invert one bit → err_pulse high exactly 1 cycle, err_cnt=1, locked stays 1, next 100 bits produce no further errors.
- Loss of lock: after lock, invert 8 bits within a 64-bit window → locked=0 the cycle after the 8th error; lock is regained 26 valid bits after clean data resumes.
- All-zero input: 200 valid zero bits → locked stays 0 and match_cnt stays 0.
- Gapped valid plus clr_cnt: in_valid toggling 1/0 gives the same lock point counted in valid bits; clr_cnt pulse together with an error → err_cnt=0.
- Async reset while LOCKED with err_cnt=5 → all outputs 0 immediately, without waiting for a clock edge.
